// File: rtl/heading_pkg.sv
// Shared types and constants for the heading key-sequencing transmitter.
package heading_pkg;
  localparam int WORD_W = 8;
  localparam int VAL_W  = 7;

  localparam logic TARGET_P = 1'b0;
  localparam logic TARGET_Q = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_CONF = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  // Heading inputData layout: target selects P/Q in the top bit.
  function automatic logic [WORD_W-1:0] pack_cmd(logic target, logic [VAL_W-1:0] value);
    return {target, value};
  endfunction
endpackage

// File: rtl/heading_sender_if.sv
// Command handshake between a host driver and heading_sender.
interface heading_sender_if;
  import heading_pkg::*;
  logic             cmd_valid;
  logic             cmd_target;
  logic [VAL_W-1:0] cmd_value;
  logic             cmd_ready;

  modport master (output cmd_valid, cmd_target, cmd_value, input cmd_ready);
  modport slave  (input cmd_valid, cmd_target, cmd_value, output cmd_ready);
endinterface

// File: rtl/heading_cmd_fifo.sv
// Small command FIFO; pointers carry an extra wrap bit to tell full from empty.
module heading_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign count   = wr_q - rd_q;
  assign dout    = mem_q[rd_q[AW-1:0]];
  // Full refuses a push even when a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (pop_ok) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) mem_q <= mem_d;
endmodule

// File: rtl/heading_sender.sv
// Replays queued P/Q write commands as request / gap / confirm / hold key sequences.
module heading_sender
  import heading_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  heading_sender_if.slave              cmd,
  output logic                         request,
  output logic                         confirm,
  output logic [WORD_W-1:0]            data_out,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int CNT_MAX = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                request_q, request_d;
  logic                confirm_q, confirm_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   fifo_dout;
  logic                fifo_full, fifo_empty, fifo_pop;

  assign cmd.cmd_ready = !fifo_full;
  assign fifo_pop      = (state_q == S_IDLE) && !fifo_empty;

  heading_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (cmd.cmd_valid),
    .din     (pack_cmd(cmd.cmd_target, cmd.cmd_value)),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: if (!fifo_empty) begin
        hold_d  = fifo_dout;
        state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: if (cnt_q == GAP_LAST) state_d = S_CONF;
             else cnt_d = cnt_q + CNT_W'(1);
      S_CONF: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: if (cnt_q == HOLD_LAST) state_d = S_IDLE;
              else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered alongside the state so they line up with it.
    request_d = (state_d == S_REQ);
    confirm_d = (state_d == S_CONF);
    data_d    = (state_d == S_IDLE) ? '0 : hold_d;
    done_d    = (state_q == S_HOLD) && (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      data_q    <= '0;
      request_q <= 1'b0;
      confirm_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      request_q <= request_d;
      confirm_q <= confirm_d;
      done_q    <= done_d;
    end
  end

  assign request  = request_q;
  assign confirm  = confirm_q;
  assign data_out = data_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE) || (fifo_count != '0);
endmodule
